// File: rtl/fp_tag_tracker_pkg.sv
// Shared types and constants for the fp_unit tag tracker.
// Holds the FIFO entry type, the in/out port bundles, the flag width and
// the NaN-boxing constant and helper used to widen single-precision results.
package fp_tag_tracker_pkg;

  localparam int unsigned FP_TAG_W   = 5;
  localparam int unsigned FP_FMT_W   = 2;
  localparam int unsigned FP_FLAGS_W = 5;
  localparam int unsigned FP_DATA_W  = 64;

  localparam logic [FP_FMT_W-1:0] FP_FMT_SINGLE = FP_FMT_W'(0);
  localparam logic [31:0]         FP_NAN_BOX    = 32'hFFFF_FFFF;

  // One in-flight op: where its result goes and how wide it is.
  typedef struct packed {
    logic [FP_TAG_W-1:0] tag;
    logic [FP_FMT_W-1:0] fmt;
  } fp_tag_entry_type;

  // Input bundle of the tracker.
  typedef struct packed {
    logic                  issue_valid;
    logic [FP_TAG_W-1:0]   issue_tag;
    logic [FP_FMT_W-1:0]   issue_fmt;
    logic                  fp_ready;
    logic [FP_DATA_W-1:0]  fp_result;
    logic [FP_FLAGS_W-1:0] fp_flags;
    logic                  fflags_clr;
  } fp_tag_tracker_in_type;

  // Output bundle of the tracker; occupancy is left out since its width
  // depends on the instance depth.
  typedef struct packed {
    logic                  issue_ready;
    logic                  wb_valid;
    logic [FP_TAG_W-1:0]   wb_tag;
    logic [FP_FMT_W-1:0]   wb_fmt;
    logic [FP_DATA_W-1:0]  wb_data;
    logic [FP_FLAGS_W-1:0] wb_flags;
    logic [FP_FLAGS_W-1:0] fflags;
    logic                  err_overflow;
    logic                  err_underflow;
  } fp_tag_tracker_out_type;

  // Single-precision results are NaN-boxed into the 64-bit register file.
  function automatic logic [FP_DATA_W-1:0] fp_nan_box(
    input logic [FP_FMT_W-1:0]  fmt,
    input logic [FP_DATA_W-1:0] result
  );
    if (fmt == FP_FMT_SINGLE) begin
      return {FP_NAN_BOX, result[31:0]};
    end
    return result;
  endfunction

endpackage

// File: rtl/fp_tag_tracker_fifo.sv
// fp_tag_fifo: generic synchronous FIFO, async active-low reset.
// Ports: clk, rst_n, push/wdata (write), pop/rdata (read, show-ahead),
//        full, empty, count (0..DEPTH).
// Pushes while full and pops while empty are ignored; pointers wrap
// naturally because DEPTH is a power of two.
module fp_tag_fifo
  import fp_tag_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = fp_tag_entry_type
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  T                             wdata,
  output T                             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_tag_tracker.sv
// fp_tag_tracker: pairs in-order fp_unit completions with their issue tags.
// Ports: clock, reset (async, active-low)
//   issue_valid/issue_tag/issue_fmt -> record an op started in fp_unit
//   issue_ready                     <- room for one more op
//   fp_ready/fp_result/fp_flags     -> fp_unit completion, in order
//   wb_valid/wb_tag/wb_fmt/wb_data/wb_flags <- registered writeback
//   fflags, fflags_clr              <- sticky accumulated flags / clear
//   inflight                        <- current occupancy
//   err_overflow/err_underflow      <- sticky protocol errors
module fp_tag_tracker
  import fp_tag_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = FP_TAG_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic [TAG_W-1:0]             issue_tag,
  input  logic [1:0]                   issue_fmt,
  output logic                         issue_ready,
  input  logic                         fp_ready,
  input  logic [63:0]                  fp_result,
  input  logic [FP_FLAGS_W-1:0]        fp_flags,
  output logic                         wb_valid,
  output logic [TAG_W-1:0]             wb_tag,
  output logic [1:0]                   wb_fmt,
  output logic [63:0]                  wb_data,
  output logic [FP_FLAGS_W-1:0]        wb_flags,
  output logic [FP_FLAGS_W-1:0]        fflags,
  input  logic                         fflags_clr,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  fp_tag_entry_type       w_wentry;
  fp_tag_entry_type       w_rentry;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  logic                   r_wb_valid;
  logic [TAG_W-1:0]       r_wb_tag;
  logic [1:0]             r_wb_fmt;
  logic [63:0]            r_wb_data;
  logic [FP_FLAGS_W-1:0]  r_wb_flags;
  logic [FP_FLAGS_W-1:0]  r_fflags;
  logic                   r_err_overflow;
  logic                   r_err_underflow;

  // Readiness ignores a same-cycle pop, so a full tracker always drops.
  assign issue_ready = ~w_full;
  assign w_push      = issue_valid & issue_ready;
  assign w_pop       = fp_ready & ~w_empty;
  assign w_wentry    = '{tag: FP_TAG_W'(issue_tag), fmt: issue_fmt};

  fp_tag_fifo #(
    .DEPTH (DEPTH),
    .T     (fp_tag_entry_type)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wentry),
    .rdata (w_rentry),
    .full  (w_full),
    .empty (w_empty),
    .count (inflight)
  );

  // Writeback register: data outputs hold between completions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_fmt   <= '0;
      r_wb_data  <= '0;
      r_wb_flags <= '0;
    end else begin
      r_wb_valid <= w_pop;
      if (w_pop) begin
        r_wb_tag   <= TAG_W'(w_rentry.tag);
        r_wb_fmt   <= w_rentry.fmt;
        r_wb_data  <= fp_nan_box(w_rentry.fmt, fp_result);
        r_wb_flags <= fp_flags;
      end
    end
  end

  // Sticky flags: a completing op's flags survive a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fflags <= '0;
    end else begin
      r_fflags <= (fflags_clr ? '0 : r_fflags) | (w_pop ? fp_flags : '0);
    end
  end

  // Protocol errors latch until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (issue_valid & w_full) r_err_overflow  <= 1'b1;
      if (fp_ready & w_empty)   r_err_underflow <= 1'b1;
    end
  end

  assign wb_valid      = r_wb_valid;
  assign wb_tag        = r_wb_tag;
  assign wb_fmt        = r_wb_fmt;
  assign wb_data       = r_wb_data;
  assign wb_flags      = r_wb_flags;
  assign fflags        = r_fflags;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_fp_tag_tracker.sv
// Bench for fp_tag_tracker: directed scenarios with literal expectations
// plus a randomized run, all cross-checked every cycle against a queue model.
module tb_fp_tag_tracker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              clock;
  logic              reset;
  logic              issue_valid;
  logic [TAG_W-1:0]  issue_tag;
  logic [1:0]        issue_fmt;
  logic              issue_ready;
  logic              fp_ready;
  logic [63:0]       fp_result;
  logic [4:0]        fp_flags;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [1:0]        wb_fmt;
  logic [63:0]       wb_data;
  logic [4:0]        wb_flags;
  logic [4:0]        fflags;
  logic              fflags_clr;
  logic [CNT_W-1:0]  inflight;
  logic              err_overflow;
  logic              err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  fp_tag_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_tag     (issue_tag),
    .issue_fmt     (issue_fmt),
    .issue_ready   (issue_ready),
    .fp_ready      (fp_ready),
    .fp_result     (fp_result),
    .fp_flags      (fp_flags),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .wb_fmt        (wb_fmt),
    .wb_data       (wb_data),
    .wb_flags      (wb_flags),
    .fflags        (fflags),
    .fflags_clr    (fflags_clr),
    .inflight      (inflight),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       fmt;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  int          m_n;
  logic        m_pop;
  logic        m_wb_valid;
  logic [4:0]  m_wb_tag;
  logic [1:0]  m_wb_fmt;
  logic [63:0] m_wb_data;
  logic [4:0]  m_wb_flags;
  logic [4:0]  m_fflags;
  logic        m_ovf;
  logic        m_unf;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_wb_valid = 1'b0; m_wb_tag = '0; m_wb_fmt = '0; m_wb_data = '0;
      m_wb_flags = '0; m_fflags = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_n   = mq.size();
      m_pop = fp_ready && (m_n != 0);
      if (issue_valid && m_n == int'(DEPTH)) m_ovf = 1'b1;
      if (fp_ready && m_n == 0)              m_unf = 1'b1;
      m_fflags   = (fflags_clr ? 5'h00 : m_fflags) | (m_pop ? fp_flags : 5'h00);
      m_wb_valid = m_pop;
      if (m_pop) begin
        m_e        = mq.pop_front();
        m_wb_tag   = m_e.tag;
        m_wb_fmt   = m_e.fmt;
        m_wb_flags = fp_flags;
        m_wb_data  = (m_e.fmt == 2'd0) ? {32'hFFFF_FFFF, fp_result[31:0]} : fp_result;
      end
      if (issue_valid && m_n < int'(DEPTH)) begin
        m_e.tag = issue_tag;
        m_e.fmt = issue_fmt;
        mq.push_back(m_e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("wb_valid",      64'(wb_valid),      64'(m_wb_valid));
    check("wb_tag",        64'(wb_tag),        64'(m_wb_tag));
    check("wb_fmt",        64'(wb_fmt),        64'(m_wb_fmt));
    check("wb_data",       wb_data,            m_wb_data);
    check("wb_flags",      64'(wb_flags),      64'(m_wb_flags));
    check("fflags",        64'(fflags),        64'(m_fflags));
    check("inflight",      64'(inflight),      64'(mq.size()));
    check("issue_ready",   64'(issue_ready),   64'(mq.size() != int'(DEPTH)));
    check("err_overflow",  64'(err_overflow),  64'(m_ovf));
    check("err_underflow", 64'(err_underflow), 64'(m_unf));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; fp_ready = 1'b0; fflags_clr = 1'b0;
  endtask

  task automatic push(input logic [TAG_W-1:0] tag, input logic [1:0] fmt);
    issue_valid = 1'b1; issue_tag = tag; issue_fmt = fmt;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_tag = '0; issue_fmt = '0;
    fp_ready = 1'b0; fp_result = '0; fp_flags = '0; fflags_clr = 1'b0;
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_inflight",    64'(inflight),      64'd0);
    check("rst_issue_ready", 64'(issue_ready),   64'd1);
    check("rst_wb_valid",    64'(wb_valid),      64'd0);
    check("rst_fflags",      64'(fflags),        64'd0);
    check("rst_err_ovf",     64'(err_overflow),  64'd0);

    // Single double-precision op
    push(5'd3, 2'd1);
    check("t1_inflight1", 64'(inflight), 64'd1);
    repeat (3) tick();
    fp_ready = 1'b1; fp_result = 64'h3FF0_0000_0000_0000; fp_flags = 5'h00;
    tick();
    fp_ready = 1'b0;
    check("t1_wb_valid", 64'(wb_valid), 64'd1);
    check("t1_wb_tag",   64'(wb_tag),   64'd3);
    check("t1_wb_data",  wb_data,       64'h3FF0_0000_0000_0000);
    check("t1_inflight", 64'(inflight), 64'd0);
    tick();
    check("t1_wb_drop",  64'(wb_valid), 64'd0);

    // Three single-precision ops, NaN-boxed, flags accumulate
    for (int t = 1; t <= 3; t++) push(TAG_W'(t), 2'd0);
    for (int t = 1; t <= 3; t++) begin
      fp_ready  = 1'b1;
      fp_result = 64'h1234_5678_3F80_0000;
      fp_flags  = (t == 1) ? 5'h01 : (t == 2) ? 5'h04 : 5'h00;
      tick();
      check("t2_wb_tag",  64'(wb_tag),  64'(t));
      check("t2_wb_data", wb_data,      64'hFFFF_FFFF_3F80_0000);
    end
    fp_ready = 1'b0;
    check("t2_fflags", 64'(fflags), 64'h05);

    // Fill, overflow, drain with pointer wrap
    for (int i = 0; i < 8; i++) push(TAG_W'(8 + i), 2'(i % 2));
    check("t3_issue_ready", 64'(issue_ready), 64'd0);
    check("t3_inflight8",   64'(inflight),    64'd8);
    push(5'd31, 2'd1);
    check("t3_err_ovf",     64'(err_overflow), 64'd1);
    check("t3_inflight_st", 64'(inflight),     64'd8);
    fp_flags = 5'h00;
    for (int i = 0; i < 8; i++) begin
      fp_ready = 1'b1; fp_result = {$urandom, $urandom};
      tick();
      check("t3_drain_tag", 64'(wb_tag), 64'(8 + i));
    end
    fp_ready = 1'b0;
    check("t3_empty", 64'(inflight), 64'd0);

    // Full push+pop in one cycle drops the push; clear vs pop on fflags
    do_reset();
    for (int i = 0; i < 8; i++) push(TAG_W'(16 + i), 2'd1);
    issue_valid = 1'b1; issue_tag = 5'd30; issue_fmt = 2'd1;
    fp_ready = 1'b1; fp_result = 64'd7; fp_flags = 5'h10;
    tick();
    issue_valid = 1'b0;
    check("t4_err_ovf",  64'(err_overflow), 64'd1);
    check("t4_count7",   64'(inflight),     64'd7);
    check("t4_wb_tag",   64'(wb_tag),       64'd16);
    check("t4_fflags10", 64'(fflags),       64'h10);
    fflags_clr = 1'b1; fp_flags = 5'h01;
    tick();
    fflags_clr = 1'b0;
    check("t5_fflags01", 64'(fflags), 64'h01);
    check("t5_wb_tag",   64'(wb_tag), 64'd17);
    fp_flags = 5'h00;
    repeat (6) tick();
    fp_ready = 1'b0;
    check("t4_last_tag", 64'(wb_tag),   64'd23);
    check("t4_drained",  64'(inflight), 64'd0);

    // Underflow, then async reset with ops in flight
    fp_ready = 1'b1; fp_flags = 5'h02;
    tick();
    fp_ready = 1'b0;
    check("t6_err_unf",   64'(err_underflow), 64'd1);
    check("t6_no_wb",     64'(wb_valid),      64'd0);
    check("t6_fflags_st", 64'(fflags),        64'h01);
    for (int i = 0; i < 4; i++) push(TAG_W'(i + 4), 2'd0);
    check("t6_inflight4", 64'(inflight), 64'd4);
    #1 reset = 1'b0;
    #1;
    check("t6_ar_inflight", 64'(inflight),      64'd0);
    check("t6_ar_wb_tag",   64'(wb_tag),        64'd0);
    check("t6_ar_wb_data",  wb_data,            64'd0);
    check("t6_ar_fflags",   64'(fflags),        64'd0);
    check("t6_ar_err_ovf",  64'(err_overflow),  64'd0);
    check("t6_ar_err_unf",  64'(err_underflow), 64'd0);
    check("t6_ar_ready",    64'(issue_ready),   64'd1);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic with varying issue/complete pressure
    for (int blk = 0; blk < 30; blk++) begin
      int p_iss;
      int p_rdy;
      p_iss = int'($urandom_range(10, 90));
      p_rdy = int'($urandom_range(10, 90));
      if (blk == 15) do_reset();
      for (int c = 0; c < 100; c++) begin
        issue_valid = ($urandom_range(0, 99) < p_iss);
        issue_tag   = TAG_W'($urandom);
        issue_fmt   = 2'($urandom_range(0, 3));
        fp_ready    = ($urandom_range(0, 99) < p_rdy);
        fp_result   = {$urandom, $urandom};
        fp_flags    = 5'($urandom);
        fflags_clr  = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_tag_tracker.md
Name: fp_tag_tracker

Overview:
Bookkeeping stage wrapped around fp_unit. The issue side pushes destination tag and format for every op it starts (fp_exe_i.enable). The completion side consumes fp_exe_o.ready/result/flags in order, pairs each result with its oldest in-flight tag, and emits a registered writeback. It also holds the sticky fflags accumulator (fcsr view) and flags protocol errors.

Parameters:
DEPTH, 8, max in-flight ops; power of two, >= fp_unit pipeline depth
TAG_W, 5, destination register tag width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
issue_valid  in  1  op issued to fp_unit this cycle; same signal as fp_exe_i.enable
issue_tag  in  TAG_W  destination register of issued op
issue_fmt  in  2  fmt of issued op; 0=single, 1=double
issue_ready  out  1  room for one more op (count < DEPTH)
fp_ready  in  1  fp_exe_o.ready
fp_result  in  64  fp_exe_o.result
fp_flags  in  5  fp_exe_o.flags {NV,DZ,OF,UF,NX}
wb_valid  out  1  writeback strobe, one cycle
wb_tag  out  TAG_W  tag of completing op
wb_fmt  out  2  fmt of completing op
wb_data  out  64  result; NaN-boxed when fmt=0
wb_flags  out  5  flags of completing op
fflags  out  5  sticky accumulated flags
fflags_clr  in  1  clear sticky flags (csr write)
inflight  out  $clog2(DEPTH+1)  current occupancy
err_overflow  out  1  sticky: push attempted while full
err_underflow  out  1  sticky: fp_ready with nothing in flight

Behaviour:
- Reset (reset=0, async): wr_ptr, rd_ptr, count, all wb_* outputs, fflags, err_* cleared to 0. issue_ready=1 once reset deasserts. In-flight entries are discarded; fp_unit is reset by the same signal, so no stale ready arrives.
- FIFO: DEPTH entries of {tag, fmt}. Pointers are log2(DEPTH) bits and wrap naturally. count is separate, 0..DEPTH. inflight = count.
- issue_ready = (count != DEPTH), combinational from registered count. It does not consider a same-cycle pop.
- Push: issue_valid & issue_ready writes the entry at wr_ptr; wr_ptr++, count++.
- Push while full: the entry is dropped and err_overflow latches 1, even if a pop happens in the same cycle.
- Pop: fp_ready & count!=0 reads the entry at rd_ptr; rd_ptr++, count--.
- fp_ready while count==0: no pop, no writeback, err_underflow latches 1. There is no push bypass: fp_unit latency is >= 1, so a same-cycle push never matches that ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Writeback registered, latency 1 cycle after fp_ready:
  - wb_valid <= pop.
  - On a pop, wb_tag/wb_fmt come from the entry, wb_flags <= fp_flags.
  - wb_data <= (fmt==0) ? {32'hFFFFFFFF, fp_result[31:0]} : fp_result.
  - When there is no pop, wb_valid=0 and the data outputs hold their last value.
- Sticky flags:
  - fflags <= (fflags_clr ? 5'b0 : fflags) | (pop ? fp_flags : 5'b0).
  - On clear plus pop in the same cycle, the popped op's flags survive the clear.
  - fflags updates in the same cycle as wb_valid.
- err_* clear only on reset.
- No writeback backpressure: the consumer accepts every wb_valid.

Decomposition:
- fp_wire package gains:
  - typedef fp_tag_entry_type {tag, fmt}
  - typedef fp_tag_tracker_in_type / fp_tag_tracker_out_type bundling the ports above
  - constant FP_FLAGS_W=5
  - NaN-box constant 32'hFFFFFFFF
- One sub-module: fp_tag_fifo. Generic synchronous FIFO with async active-low reset; ports push, pop, wdata, rdata, full, empty, count; parameterised on DEPTH and entry type.
- The top level holds the writeback register, NaN-boxing, fflags and the error flags.

Test Plan:
- Reset, then issue tag 3 fmt 1; fp_ready with result 64'h3FF0000000000000, flags 0 four cycles later -> next cycle wb_valid=1, wb_tag=3, wb_data=64'h3FF0000000000000, inflight back to 0.
- Issue tags 1,2,3 (fmt 0) back to back, then three fp_ready pulses carrying result 32'h3F800000 and flags 5'h01, 5'h04, 5'h00 -> wb_tag sequence 1,2,3; wb_data=64'hFFFFFFFF3F800000; fflags=5'h05.
- Fill 8 entries -> issue_ready=0, inflight=8. Issue a 9th op -> err_overflow=1, inflight stays 8. Drain 8 -> tags pop in push order, pointer wrap verified.
- At count=8, push and pop in the same cycle -> push dropped, err_overflow=1, count=7.
- fflags=5'h10, then fflags_clr together with a pop carrying flags 5'h01 -> fflags=5'h01.
- fp_ready with empty tracker -> err_underflow=1, no wb_valid. Assert reset mid-stream with 4 in flight -> all outputs 0, inflight=0 asynchronously, before the next clock edge.
